// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_pkg
// Description : Shared ALU op codes, LEGv8 opcode match patterns and the
//               opcode decode function for the execute-stage issue block.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    localparam int DEF_OPC_W = 11;
    localparam int DEF_CNT_W = 32;

    // 4-bit ALU control codes; ALU_NOP drives a zero result
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_ORR = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_CPZ = 4'b0111,
        ALU_NOP = 4'b1111
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    use_imm;
        logic    force_b_zero;
        logic    is_branch;
        logic    is_cbnz;
        logic    illegal;
    } decode_t;

    // Match patterns (don't-care bits zero) and the masks selecting cared bits
    localparam logic [DEF_OPC_W-1:0] PAT_ADD  = 11'b100_0101_1000;
    localparam logic [DEF_OPC_W-1:0] PAT_SUB  = 11'b110_0101_1000;
    localparam logic [DEF_OPC_W-1:0] PAT_AND  = 11'b100_0101_0000;
    localparam logic [DEF_OPC_W-1:0] PAT_ORR  = 11'b101_0101_0000;
    localparam logic [DEF_OPC_W-1:0] PAT_LDUR = 11'b111_1100_0010;
    localparam logic [DEF_OPC_W-1:0] PAT_STUR = 11'b111_1100_0000;
    localparam logic [DEF_OPC_W-1:0] PAT_ADDI = 11'b100_1000_1000;
    localparam logic [DEF_OPC_W-1:0] PAT_SUBI = 11'b110_1000_1000;
    localparam logic [DEF_OPC_W-1:0] PAT_CBZ  = 11'b101_1010_0000;
    localparam logic [DEF_OPC_W-1:0] PAT_CBNZ = 11'b101_1010_1000;
    localparam logic [DEF_OPC_W-1:0] PAT_B    = 11'b000_1010_0000;

    localparam logic [DEF_OPC_W-1:0] MSK_R    = 11'b111_1111_1111;
    localparam logic [DEF_OPC_W-1:0] MSK_I    = 11'b111_1111_1110;
    localparam logic [DEF_OPC_W-1:0] MSK_CB   = 11'b111_1111_1000;
    localparam logic [DEF_OPC_W-1:0] MSK_B    = 11'b111_1110_0000;

    function automatic logic opc_match(input logic [DEF_OPC_W-1:0] opc,
                                       input logic [DEF_OPC_W-1:0] pat,
                                       input logic [DEF_OPC_W-1:0] msk);
        return (opc & msk) == pat;
    endfunction

    // Longest patterns are tested first so wider don't-care classes never
    // shadow an exact encoding.
    function automatic decode_t decode(input logic [DEF_OPC_W-1:0] opc);
        decode_t d;
        d.alu_op       = ALU_NOP;
        d.use_imm      = 1'b0;
        d.force_b_zero = 1'b0;
        d.is_branch    = 1'b0;
        d.is_cbnz      = 1'b0;
        d.illegal      = 1'b0;
        if (opc_match(opc, PAT_ADD, MSK_R)) begin
            d.alu_op = ALU_ADD;
        end else if (opc_match(opc, PAT_SUB, MSK_R)) begin
            d.alu_op = ALU_SUB;
        end else if (opc_match(opc, PAT_AND, MSK_R)) begin
            d.alu_op = ALU_AND;
        end else if (opc_match(opc, PAT_ORR, MSK_R)) begin
            d.alu_op = ALU_ORR;
        end else if (opc_match(opc, PAT_LDUR, MSK_R) || opc_match(opc, PAT_STUR, MSK_R)) begin
            d.alu_op  = ALU_ADD;
            d.use_imm = 1'b1;
        end else if (opc_match(opc, PAT_ADDI, MSK_I)) begin
            d.alu_op  = ALU_ADD;
            d.use_imm = 1'b1;
        end else if (opc_match(opc, PAT_SUBI, MSK_I)) begin
            d.alu_op  = ALU_SUB;
            d.use_imm = 1'b1;
        end else if (opc_match(opc, PAT_CBZ, MSK_CB)) begin
            d.alu_op    = ALU_CPZ;
            d.is_branch = 1'b1;
        end else if (opc_match(opc, PAT_CBNZ, MSK_CB)) begin
            d.alu_op    = ALU_CPZ;
            d.is_branch = 1'b1;
            d.is_cbnz   = 1'b1;
        end else if (opc_match(opc, PAT_B, MSK_B)) begin
            d.alu_op       = ALU_CPZ;
            d.is_branch    = 1'b1;
            d.force_b_zero = 1'b1;
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_alu
// Description : Combinational 64-bit ALU (AND/ORR/ADD/SUB/pass-B) with zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl_alu
    import alu_issue_ctrl_pkg::*;
(
    input  alu_op_e     op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output logic        zero
);

    // Operation select; unknown codes yield zero
    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_CPZ: result = b;
            default: result = '0;
        endcase
    end

    assign zero = (result == 64'd0);

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Execute-stage issue front end: decodes the LEGv8 opcode,
//               drives the ALU, registers result/zero/branch decision behind
//               a valid/ready stage and counts retired and taken handoffs.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OPC_W = DEF_OPC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [63:0]      in_imm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic             out_zero,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [CNT_W-1:0] cnt_retired,
    output logic [CNT_W-1:0] cnt_taken
);

    decode_t     dec;
    logic [63:0] b_sel;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic        taken_d;
    logic        accept;
    logic        handoff;

    assign dec = decode(in_opcode);

    // B operand: unconditional branch forces zero, immediates override Rm/Rt
    always_comb begin
        b_sel = in_b;
        if (dec.force_b_zero) begin
            b_sel = '0;
        end else if (dec.use_imm) begin
            b_sel = in_imm;
        end
    end

    alu_issue_ctrl_alu u_alu (
        .op     (dec.alu_op),
        .a      (in_a),
        .b      (b_sel),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // B is always taken; CBZ/CBNZ resolve on the pass-B zero flag
    assign taken_d  = dec.is_branch &
                      (dec.force_b_zero | (dec.is_cbnz ? ~alu_zero : alu_zero));

    assign in_ready = ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    // A flushed entry is killed rather than handed off
    assign handoff  = out_valid & out_ready & ~flush;

    // Output stage: load on accept, empty on flush or on an unreplaced handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_is_branch <= 1'b0;
            out_taken     <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_result    <= alu_result;
            out_zero      <= alu_zero;
            out_is_branch <= dec.is_branch;
            out_taken     <= taken_d;
            out_illegal   <= dec.illegal;
        end else if (handoff) begin
            out_valid <= 1'b0;
        end
    end

    // Performance counters advance only on a real handoff and wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_retired <= '0;
            cnt_taken   <= '0;
        end else if (handoff) begin
            if (!out_illegal) begin
                cnt_retired <= cnt_retired + CNT_W'(1);
            end
            if (out_taken) begin
                cnt_taken <= cnt_taken + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl: directed vector table,
//               hand sequences for stall/flush/reset/wrap and random traffic
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [10:0] in_opcode;
    logic [63:0] in_a, in_b, in_imm;
    logic        in_ready, out_valid, out_zero, out_is_branch, out_taken, out_illegal;
    logic [63:0] out_result;
    logic [31:0] cnt_retired, cnt_taken;
    logic        w4_in_ready, w4_out_valid, w4_zero, w4_br, w4_tk, w4_ill;
    logic [63:0] w4_result;
    logic [3:0]  w4_retired, w4_taken;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_is_branch(out_is_branch),
        .out_taken(out_taken), .out_illegal(out_illegal),
        .cnt_retired(cnt_retired), .cnt_taken(cnt_taken)
    );

    // Narrow-counter copy driven by the same stimulus, used for wrap checks
    alu_issue_ctrl #(.CNT_W(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w4_in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .flush(flush), .out_valid(w4_out_valid), .out_ready(out_ready),
        .out_result(w4_result), .out_zero(w4_zero), .out_is_branch(w4_br),
        .out_taken(w4_tk), .out_illegal(w4_ill),
        .cnt_retired(w4_retired), .cnt_taken(w4_taken)
    );

    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        br;
        logic        tk;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [10:0] op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [63:0] res;
        logic        zero;
        logic        br;
        logic        tk;
        logic        ill;
    } vec_t;

    // Reference model state: one buffered instruction plus the two counters
    logic        m_valid;
    exp_t        m_out;
    int unsigned m_ret;
    int unsigned m_tak;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction semantics straight from the LEGv8 subset definition
    function automatic exp_t model_exec(input logic [10:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input logic [63:0] imm);
        exp_t e;
        e.res = 64'd0; e.br = 1'b0; e.tk = 1'b0; e.ill = 1'b0;
        casez (op)
            11'b10001011000: e.res = a + b;
            11'b11001011000: e.res = a - b;
            11'b10001010000: e.res = a & b;
            11'b10101010000: e.res = a | b;
            11'b11111000010,
            11'b11111000000: e.res = a + imm;
            11'b1001000100?: e.res = a + imm;
            11'b1101000100?: e.res = a - imm;
            11'b10110100???: begin e.res = b; e.br = 1'b1; e.tk = (b == 64'd0); end
            11'b10110101???: begin e.res = b; e.br = 1'b1; e.tk = (b != 64'd0); end
            11'b000101?????: begin e.res = 64'd0; e.br = 1'b1; e.tk = 1'b1; end
            default:         e.ill = 1'b1;
        endcase
        e.zero = (e.res == 64'd0);
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ret   = 0;
        m_tak   = 0;
        m_out   = '{res: 64'd0, zero: 1'b0, br: 1'b0, tk: 1'b0, ill: 1'b0};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " out_valid"},   {63'd0, out_valid},     64'd0);
        chk({tag, " out_result"},  out_result,             64'd0);
        chk({tag, " out_zero"},    {63'd0, out_zero},      64'd0);
        chk({tag, " out_is_branch"}, {63'd0, out_is_branch}, 64'd0);
        chk({tag, " out_taken"},   {63'd0, out_taken},     64'd0);
        chk({tag, " out_illegal"}, {63'd0, out_illegal},   64'd0);
        chk({tag, " cnt_retired"}, {32'd0, cnt_retired},   64'd0);
        chk({tag, " cnt_taken"},   {32'd0, cnt_taken},     64'd0);
        chk({tag, " w4 out_valid"}, {63'd0, w4_out_valid}, 64'd0);
        chk({tag, " w4 cnt_retired"}, {60'd0, w4_retired}, 64'd0);
    endtask

    // One clock: drive at the falling edge, check ready, advance model, check outputs
    task automatic cycle(input logic v, input logic [10:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm,
                         input logic fl, input logic ordy);
        logic exp_ready, acc, ho;
        in_valid = v; in_opcode = op; in_a = a; in_b = b; in_imm = imm;
        flush = fl; out_ready = ordy;
        #1;
        exp_ready = !fl && (!m_valid || ordy);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        acc = v && exp_ready;
        ho  = m_valid && ordy && !fl;
        if (ho) begin
            if (!m_out.ill) m_ret++;
            if (m_out.tk)   m_tak++;
        end
        if (fl)        m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_out   = model_exec(op, a, b, imm);
        end else if (ho) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid",      {63'd0, out_valid},    {63'd0, m_valid});
        chk("cnt_retired",    {32'd0, cnt_retired},  {32'd0, m_ret});
        chk("cnt_taken",      {32'd0, cnt_taken},    {32'd0, m_tak});
        chk("w4 cnt_retired", {60'd0, w4_retired},   {60'd0, m_ret[3:0]});
        chk("w4 cnt_taken",   {60'd0, w4_taken},     {60'd0, m_tak[3:0]});
        if (m_valid) begin
            chk("out_result",    out_result,             m_out.res);
            chk("out_zero",      {63'd0, out_zero},      {63'd0, m_out.zero});
            chk("out_is_branch", {63'd0, out_is_branch}, {63'd0, m_out.br});
            chk("out_taken",     {63'd0, out_taken},     {63'd0, m_out.tk});
            chk("out_illegal",   {63'd0, out_illegal},   {63'd0, m_out.ill});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 11'd0, 64'd0, 64'd0, 64'd0, 1'b0, ordy);
    endtask

    initial begin
        vec_t        tbl[12];
        logic [10:0] op;
        logic [63:0] ra, rb, ri, held;

        tbl[0]  = '{OP_ADD,  64'd5, 64'd7,  64'd0,  64'd12, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{OP_SUBI, 64'd3, 64'd9,  64'd3,  64'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{OP_SUB,  64'd0, 64'd1,  64'd0,  ONES,   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{OP_CBZ,  64'd4, 64'd0,  64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{OP_CBNZ, 64'd4, 64'd0,  64'd0,  64'd0,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{OP_B | 11'd17, 64'd9, 64'h55, 64'd3, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{11'd0,   64'd8, 64'd8,  64'd8,  64'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{OP_AND,  64'hF0F0, 64'hFF00, 64'd0, 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{OP_ORR,  64'hF0F0, 64'h0F0F, 64'd0, 64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{OP_LDUR, 64'h100, 64'd77, 64'h20, 64'h120, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_ADDI | 11'd1, ONES, 64'd0, 64'd2, 64'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{OP_CBNZ | 11'd5, 64'd0, 64'd5, 64'd0, 64'd5, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_imm = '0;
        flush = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Directed vectors at full rate
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, 1'b0, 1'b1);
            chk("vec result",  out_result,               tbl[i].res);
            chk("vec zero",    {63'd0, out_zero},        {63'd0, tbl[i].zero});
            chk("vec branch",  {63'd0, out_is_branch},   {63'd0, tbl[i].br});
            chk("vec taken",   {63'd0, out_taken},       {63'd0, tbl[i].tk});
            chk("vec illegal", {63'd0, out_illegal},     {63'd0, tbl[i].ill});
        end
        idle(1'b1);
        // 11 legal (opcode 0 excluded), taken: CBZ, B, CBNZ(5)
        chk("vec total retired", {32'd0, cnt_retired}, 64'd11);
        chk("vec total taken",   {32'd0, cnt_taken},   64'd3);

        // Backpressure: stall three cycles with a waiting instruction, then burst
        cycle(1'b1, OP_ADD, 64'd100, 64'd23, 64'd0, 1'b0, 1'b0);
        held = out_result;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, OP_SUB, 64'd50 + 64'(i), 64'd1, 64'd0, 1'b0, 1'b0);
            chk("stall in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall held result", out_result, held);
        end
        for (int i = 0; i < 4; i++)
            cycle(1'b1, OP_ADDI, 64'(i), 64'd0, 64'd1000, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while a valid result is being consumed
        cycle(1'b1, OP_CBZ, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        cycle(1'b1, OP_ORR, 64'd1, 64'd2, 64'd0, 1'b1, 1'b1);
        chk("flush out_valid", {63'd0, out_valid}, 64'd0);
        idle(1'b1);
        chk("post-flush out_valid", {63'd0, out_valid}, 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 11))
                0:  op = OP_ADD;
                1:  op = OP_SUB;
                2:  op = OP_AND;
                3:  op = OP_ORR;
                4:  op = OP_LDUR;
                5:  op = OP_STUR;
                6:  op = OP_ADDI | 11'($urandom_range(0, 1));
                7:  op = OP_SUBI | 11'($urandom_range(0, 1));
                8:  op = OP_CBZ  | 11'($urandom_range(0, 7));
                9:  op = OP_CBNZ | 11'($urandom_range(0, 7));
                10: op = OP_B    | 11'($urandom_range(0, 31));
                default: op = 11'($urandom);
            endcase
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            ri = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, op, ra, rb, ri,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        idle(1'b1);

        // Asynchronous reset in the middle of a transfer
        cycle(1'b1, OP_ADD, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Sixteen legal handoffs wrap a 4-bit counter back to zero
        for (int i = 0; i < 16; i++)
            cycle(1'b1, OP_ADD, 64'(i), 64'd1, 64'd0, 1'b0, 1'b1);
        idle(1'b1);
        chk("wrap w4 cnt_retired", {60'd0, w4_retired}, 64'd0);
        chk("wrap cnt_retired",    {32'd0, cnt_retired}, 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
